fault_sim_sequencer: RTL and testbench
======================================

FAULT_SIM_SEQUENCER -- requirements
Module: fault_sim_sequencer

Interface
REQ-001 SHALL have parameter NUM_FAULTS, default 6508, number of entries in the collapsed fault list.
REQ-002 SHALL have parameter NUM_PATTERNS, default 51, number of test vectors in the pattern store.
REQ-003 SHALL have parameter IN_W, default 32, circuit-under-test input width.
REQ-004 SHALL have parameter OUT_W, default 32, circuit-under-test output width.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 4 (min 1), cycles allowed for good and faulty copies to settle.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports: start  in  1  begin a campaign; honoured only in IDLE or DONE.
REQ-009 SHALL have ports: busy  out  1  campaign in progress.
REQ-010 SHALL have ports: done  out  1  campaign finished; held until next start.
REQ-011 SHALL have ports: fault_idx  out  clog2(NUM_FAULTS)  fault being injected.
REQ-012 SHALL have ports: inject_en  out  1  fault-injection enable to the faulty copy.
REQ-013 SHALL have ports: pat_addr  out  clog2(NUM_PATTERNS)  pattern store read address.
REQ-014 SHALL have ports: pat_data  in  IN_W  pattern store read data, valid one cycle after pat_addr.
REQ-015 SHALL have ports: dut_in  out  IN_W  vector driven to both copies.
REQ-016 SHALL have ports: good_out / faulty_out  in  OUT_W each  responses of good and faulty copies.
REQ-017 SHALL have ports: dict_valid  out  1, dict_ready  in  1, dict_fault  out  clog2(NUM_FAULTS), dict_syndrome  out  NUM_PATTERNS  dictionary record stream.
REQ-018 SHALL have ports: detected_cnt  out  clog2(NUM_FAULTS+1)  faults with non-zero syndrome.

Function
REQ-019 SHALL implement states IDLE, INJECT, FETCH, SETTLE, COMPARE, EMIT, RELEASE, DONE.
REQ-020 SHALL on start in IDLE/DONE: clear fault_idx, detected_cnt, done; go INJECT; busy=1 in every state except IDLE and DONE.
REQ-021 SHALL in INJECT: assert inject_en (held through RELEASE), clear pattern index and syndrome, go FETCH next cycle.
REQ-022 SHALL in FETCH: drive pat_addr=pattern index for one cycle, then load dut_in<=pat_data on entry to SETTLE.
REQ-023 SHALL stay in SETTLE exactly SETTLE_CYCLES cycles, then go COMPARE.
REQ-024 SHALL in COMPARE: set syndrome[pattern index]=(good_out!=faulty_out); if index==NUM_PATTERNS-1 go EMIT, else increment index and go FETCH.
REQ-025 SHALL per pattern take 1+1+SETTLE_CYCLES+1 cycles (FETCH, load, settle, compare); dut_in holds its value until the next load.
REQ-026 SHALL in EMIT: hold dict_valid=1 with stable dict_fault=fault_idx and dict_syndrome until dict_ready=1; transfer on the cycle both are high.
REQ-027 SHALL on transfer increment detected_cnt if syndrome!=0, then go RELEASE.
REQ-028 SHALL in RELEASE: deassert inject_en for one cycle; if fault_idx==NUM_FAULTS-1 go DONE, else increment fault_idx and go INJECT.
REQ-029 SHALL in DONE: done=1, busy=0, detected_cnt held; start restarts the campaign.
REQ-030 SHALL ignore start while busy; dict_ready outside EMIT has no effect.
REQ-031 SHALL never have inject_en high in IDLE or DONE, so one fault at most is active at any time.

Reset
REQ-032 SHALL on rst_n=0 at a clock edge enter IDLE and zero busy, done, inject_en, dict_valid, fault_idx, pat_addr, dut_in, dict_fault, dict_syndrome, detected_cnt.
REQ-033 SHALL abort any campaign when reset occurs mid-operation, with no partial record emitted.

Configuration
REQ-034 SHALL with FAULT_DROP_EN defined: after a COMPARE mismatch, go directly to EMIT, leaving untested syndrome bits 0.
REQ-035 SHALL without FAULT_DROP_EN: always apply all NUM_PATTERNS patterns per fault.

Verification
REQ-036 SHALL cover NUM_FAULTS=3, NUM_PATTERNS=4, faulty copy mismatching only on pattern 2 for fault 1 -> records {0,4'b0000},{1,4'b0100},{2,4'b0000}, detected_cnt=1, done=1.
REQ-037 SHALL cover dict_ready held low 10 cycles in EMIT -> dict_valid high and dict_fault/dict_syndrome stable throughout; exactly one transfer.
REQ-038 SHALL cover rst_n=0 during SETTLE of fault 1 -> next cycle IDLE, inject_en=0, all outputs zero, no further record.
REQ-039 SHALL cover FAULT_DROP_EN with mismatch on patterns 0 and 3 -> syndrome 4'b0001, EMIT reached after pattern 0.
REQ-040 SHALL cover SETTLE_CYCLES=4, NUM_PATTERNS=4, dict_ready tied high -> 28 cycles from INJECT exit to EMIT entry.
REQ-041 SHALL cover start pulsed while busy -> ignored; start in DONE -> detected_cnt cleared, campaign rerun.

Source files
------------

// File: rtl/fault_sim_sequencer.sv
// fault_sim_sequencer
// Runs a serial fault-simulation campaign. For every fault in the collapsed
// list, the sequencer enables injection into the faulty copy and applies every
// pattern from the pattern store to both copies. It compares their responses
// and emits one dictionary record (fault index plus per-pattern syndrome) over
// a valid/ready stream.
//
// Build option: define FAULT_DROP_EN to stop a fault at its first detecting
// pattern. Syndrome bits for patterns that were not applied stay 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start               begin a campaign (honoured only in IDLE or DONE)
//   busy, done          campaign in progress / campaign finished
//   fault_idx           fault currently selected for injection
//   inject_en           injection enable to the faulty copy
//   pat_addr, pat_data  pattern store read port (1-cycle read latency)
//   dut_in              vector applied to both copies
//   good_out,faulty_out responses of good and faulty copies
//   dict_*              dictionary record stream (valid/ready)
//   detected_cnt        number of faults with a non-zero syndrome
module fault_sim_sequencer #(
    parameter int unsigned NUM_FAULTS    = 6508,
    parameter int unsigned NUM_PATTERNS  = 51,
    parameter int unsigned IN_W          = 32,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    localparam int unsigned FW = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
    localparam int unsigned PW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int unsigned CW = $clog2(NUM_FAULTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [FW-1:0]           fault_idx,
    output logic                    inject_en,
    output logic [PW-1:0]           pat_addr,
    input  logic [IN_W-1:0]         pat_data,
    output logic [IN_W-1:0]         dut_in,
    input  logic [OUT_W-1:0]        good_out,
    input  logic [OUT_W-1:0]        faulty_out,
    output logic                    dict_valid,
    input  logic                    dict_ready,
    output logic [FW-1:0]           dict_fault,
    output logic [NUM_PATTERNS-1:0] dict_syndrome,
    output logic [CW-1:0]           detected_cnt
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INJECT  = 3'd1,
        S_FETCH   = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_EMIT    = 3'd5,
        S_RELEASE = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [PW-1:0]   pat_idx;
    logic [SW-1:0]   settle_cnt;
    logic            fetch_ph;      // 0: address presented, 1: read data valid
    logic            busy_d;
    logic            done_d;
    logic            inject_en_d;
    logic            dict_valid_d;

    logic            cmp_diff;
    logic            last_pat;
    logic            last_fault;
    logic            settle_end;
    logic            pat_stop;

    assign cmp_diff   = (good_out != faulty_out);
    assign last_pat   = (pat_idx == PW'(NUM_PATTERNS - 1));
    assign last_fault = (fault_idx == FW'(NUM_FAULTS - 1));
    assign settle_end = (settle_cnt == SW'(SETTLE_CYCLES - 1));

    // Leave the pattern loop after the last pattern, or on first detection when dropping
`ifdef FAULT_DROP_EN
    assign pat_stop = last_pat || cmp_diff;
`else
    assign pat_stop = last_pat;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_INJECT;
                end
            end
            S_INJECT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_ph) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_end) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                state_d = pat_stop ? S_EMIT : S_FETCH;
            end
            S_EMIT: begin
                if (dict_ready) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = last_fault ? S_DONE : S_INJECT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode of the state being entered; registered below so the flops track state_q
    always_comb begin
        busy_d       = 1'b1;
        done_d       = 1'b0;
        inject_en_d  = 1'b0;
        dict_valid_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            S_INJECT, S_FETCH, S_SETTLE, S_COMPARE: begin
                inject_en_d = 1'b1;
            end
            S_EMIT: begin
                inject_en_d  = 1'b1;
                dict_valid_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // Datapath: fault/pattern indices, vector load, syndrome and record registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            inject_en     <= 1'b0;
            dict_valid    <= 1'b0;
            fault_idx     <= '0;
            pat_addr      <= '0;
            dut_in        <= '0;
            dict_fault    <= '0;
            dict_syndrome <= '0;
            detected_cnt  <= '0;
            pat_idx       <= '0;
            settle_cnt    <= '0;
            fetch_ph      <= 1'b0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            inject_en  <= inject_en_d;
            dict_valid <= dict_valid_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        fault_idx    <= '0;
                        detected_cnt <= '0;
                    end
                end
                S_INJECT: begin
                    pat_idx       <= '0;
                    pat_addr      <= '0;
                    dict_syndrome <= '0;
                    fetch_ph      <= 1'b0;
                end
                S_FETCH: begin
                    fetch_ph   <= ~fetch_ph;
                    settle_cnt <= '0;
                    if (fetch_ph) begin
                        dut_in <= pat_data;
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
                S_COMPARE: begin
                    dict_syndrome[pat_idx] <= cmp_diff;
                    if (pat_stop) begin
                        dict_fault <= fault_idx;
                    end else begin
                        pat_idx  <= pat_idx + PW'(1);
                        pat_addr <= pat_idx + PW'(1);
                        fetch_ph <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (dict_ready && (dict_syndrome != '0)) begin
                        detected_cnt <= detected_cnt + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (!last_fault) begin
                        fault_idx <= fault_idx + FW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// Self-checking bench for fault_sim_sequencer: 3 faults, 4 patterns, 4 settle cycles.
// The faulty copy differs from the good copy on the patterns flagged in a per-fault
// mismatch table. Expected dictionary records come from that table.
module tb_fault_sim_sequencer;

    localparam int unsigned NF = 3;
    localparam int unsigned NP = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned OW = 8;
    localparam int unsigned SC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    fault_idx;
    logic          inject_en;
    logic [1:0]    pat_addr;
    logic [IW-1:0] pat_data;
    logic [IW-1:0] dut_in;
    logic [OW-1:0] good_out;
    logic [OW-1:0] faulty_out;
    logic          dict_valid;
    logic          dict_ready;
    logic [1:0]    dict_fault;
    logic [NP-1:0] dict_syndrome;
    logic [1:0]    detected_cnt;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] pat_mem [NP];
    logic [11:0]   cur_mism;   // bit 4*f+p: fault f is visible on pattern p

    always #5 clk = ~clk;

    fault_sim_sequencer #(
        .NUM_FAULTS(NF), .NUM_PATTERNS(NP), .IN_W(IW), .OUT_W(OW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .fault_idx(fault_idx), .inject_en(inject_en), .pat_addr(pat_addr),
        .pat_data(pat_data), .dut_in(dut_in), .good_out(good_out),
        .faulty_out(faulty_out), .dict_valid(dict_valid), .dict_ready(dict_ready),
        .dict_fault(dict_fault), .dict_syndrome(dict_syndrome),
        .detected_cnt(detected_cnt)
    );

    // Pattern store with one cycle of read latency
    always @(posedge clk) pat_data <= pat_mem[pat_addr];

    // Circuit copies: pattern number is carried in the low two bits of each vector
    assign good_out = dut_in ^ 8'hA5;
    always_comb begin
        faulty_out = good_out;
        if (inject_en && fault_idx < 2'd3 && cur_mism[{fault_idx, dut_in[1:0]}])
            faulty_out = good_out ^ 8'h01;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: the syndrome a fault should report for its mismatch set
    function automatic logic [3:0] model_syn(input logic [3:0] m);
        logic [3:0] neg;
        neg = 4'd0 - m;
`ifdef FAULT_DROP_EN
        return m & neg;   // only the first detecting pattern is applied
`else
        return m | (neg & 4'd0);
`endif
    endfunction

    function automatic logic [11:0] model_dict(input logic [11:0] m);
        logic [11:0] r;
        for (int f = 0; f < 3; f++) r[4*f +: 4] = model_syn(m[4*f +: 4]);
        return r;
    endfunction

    function automatic int unsigned model_cnt(input logic [11:0] m);
        int unsigned c = 0;
        for (int f = 0; f < 3; f++) if (model_syn(m[4*f +: 4]) != 4'd0) c++;
        return c;
    endfunction

    // One full campaign from IDLE/DONE; checks every record and the final state
    task automatic run_campaign(input string name, input logic [11:0] m, input logic [11:0] e,
                                input int unsigned ecnt, input int unsigned stall, input bit rnd);
        int cyc = 0;
        int nrec = 0;
        int unsigned stall_left = 0;
        bit in_emit = 0;
        cur_mism = m;
        @(negedge clk); start = 1'b1; dict_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        check({name, " start"}, 32'({busy, done, detected_cnt, fault_idx}), 32'({1'b1, 1'b0, 2'd0, 2'd0}));
        while (!done && cyc < 3000) begin
            cyc++;
            check({name, " inject gated"}, 32'(inject_en & ~busy), 32'd0);
            if (dict_valid) begin
                if (!in_emit) begin in_emit = 1; stall_left = stall; end
                if (nrec < 3) begin
                    check({name, " dict_fault"}, 32'(dict_fault), 32'(nrec));
                    check({name, " dict_syndrome"}, 32'(dict_syndrome), 32'(e[4*nrec +: 4]));
                end else begin
                    check({name, " extra record"}, 32'(nrec), 32'd2);
                end
                if (stall_left > 0) begin dict_ready = 1'b0; stall_left--; end
                else dict_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (dict_ready) begin nrec++; in_emit = 0; end
            end else begin
                dict_ready = 1'($urandom_range(0, 1));
            end
            start = (rnd && busy) ? ($urandom_range(0, 5) == 0) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0; dict_ready = 1'b0;
        check({name, " done"}, 32'({done, busy, inject_en}), 32'({1'b1, 1'b0, 1'b0}));
        check({name, " records"}, 32'(nrec), 32'd3);
        check({name, " detected_cnt"}, 32'(detected_cnt), 32'(ecnt));
    endtask

    typedef struct {
        logic [11:0] m;
        logic [11:0] e;
        int unsigned cnt;
        int unsigned stall;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int n;
        bit bad;
        logic [11:0] rm;

        tbl[0] = '{m: 12'h040, e: 12'h040, cnt: 1, stall: 10};
`ifdef FAULT_DROP_EN
        tbl[1] = '{m: 12'h80F, e: 12'h801, cnt: 2, stall: 0};
        tbl[3] = '{m: 12'h169, e: 12'h121, cnt: 3, stall: 2};
`else
        tbl[1] = '{m: 12'h80F, e: 12'h80F, cnt: 2, stall: 0};
        tbl[3] = '{m: 12'h169, e: 12'h169, cnt: 3, stall: 2};
`endif
        tbl[2] = '{m: 12'h000, e: 12'h000, cnt: 0, stall: 1};

        for (int i = 0; i < int'(NP); i++) pat_mem[i] = {6'($urandom), 2'(i)};
        cur_mism = '0;
        rst_n = 1'b0; start = 1'b0; dict_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ctrl", 32'({busy, done, inject_en, dict_valid}), 32'd0);
        check("reset idx", 32'({fault_idx, pat_addr, dict_fault, detected_cnt}), 32'd0);
        check("reset data", 32'({dut_in, dict_syndrome}), 32'd0);
        rst_n = 1'b1;

        // Latency from INJECT to EMIT; fault 0 visible on patterns 0 and 3
        cur_mism = 12'h009;
        dict_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("timing inject_en", 32'(inject_en), 32'd1);
        n = 0;
        while (!dict_valid && n < 200) begin @(negedge clk); n++; end
`ifdef FAULT_DROP_EN
        check("inject to emit", 32'(n), 32'd8);
        check("drop syndrome", 32'(dict_syndrome), 32'h1);
`else
        check("inject to emit", 32'(n), 32'd29);
        check("full syndrome", 32'(dict_syndrome), 32'h9);
`endif
        n = 0;
        while (!done && n < 500) begin @(negedge clk); n++; end
        check("timing done", 32'({done, detected_cnt}), 32'({1'b1, 2'd1}));

        // Directed table, each campaign restarted from DONE
        for (int i = 0; i < 4; i++)
            run_campaign($sformatf("tbl%0d", i), tbl[i].m, tbl[i].e, tbl[i].cnt, tbl[i].stall, 1'b0);

        // Random campaigns with random ready and start pulses while busy
        for (int i = 0; i < 6; i++) begin
            rm = 12'($urandom);
            run_campaign($sformatf("rnd%0d", i), rm, model_dict(rm), model_cnt(rm), 0, 1'b1);
        end

        // Reset during SETTLE of fault 1 aborts with no further record
        cur_mism = 12'hFFF;
        dict_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(inject_en && fault_idx == 2'd1) && n < 500) begin @(negedge clk); n++; end
        check("reach fault 1", 32'(fault_idx), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort ctrl", 32'({busy, done, inject_en, dict_valid}), 32'd0);
        check("abort data", 32'({fault_idx, pat_addr, dict_fault, detected_cnt, dut_in, dict_syndrome}), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (dict_valid || busy || inject_en || done) bad = 1;
        end
        check("idle after abort", 32'(bad), 32'd0);

        run_campaign("after abort", tbl[0].m, tbl[0].e, tbl[0].cnt, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
